// File: rtl/pp_host_sequencer_if.sv
// Host command/response bundle for the parallel-programming sequencer.
// The sequencer is the slave; the host-side controller is the master.
interface pp_host_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );
endinterface

// File: rtl/pp_host_sequencer.sv
// Parallel-programming host sequencer: turns host commands into
// XTAL1/WR/OE strobe sequences with XA/BS1/DATA setup and hold.
module pp_host_sequencer #(
    parameter int SETUP_CYC   = 1,
    parameter int PULSE_CYC   = 2,
    parameter int RDY_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pp_host_sequencer_if.slave        bus,
    output logic                      XTAL1,
    output logic [1:0]                XA,
    output logic                      BS1,
    output logic                      WR,
    output logic                      OE,
    output logic [7:0]                DATA,
    input  logic [7:0]                data_in,
    input  logic                      RDY
);

    localparam int CMAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int WW   = $clog2(RDY_TIMEOUT + 1);

    localparam logic [CW-1:0] SET_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PUL_LD = CW'(PULSE_CYC - 1);
    localparam logic [WW-1:0] W_LAST = WW'(RDY_TIMEOUT - 1);

    localparam logic [2:0] OP_LOAD_CMD   = 3'd0;
    localparam logic [2:0] OP_LOAD_ADDR  = 3'd1;
    localparam logic [2:0] OP_LOAD_DATA  = 3'd2;
    localparam logic [2:0] OP_WRITE_PAGE = 3'd3;
    localparam logic [2:0] OP_READ_WORD  = 3'd4;
    localparam logic [2:0] OP_CHIP_ERASE = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        WAIT_RDY,
        SAMPLE,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] opnd_q, opnd_d;
    logic        ph_q, ph_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic        err_q, err_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        init_q, init_d;

    // Phase classification of the latched op; ph_q selects first/second phase.
    logic is_rd;
    logic is_wr_ph;
    logic is_ld_ph;
    logic two_ph;

    assign is_rd    = (op_q == OP_READ_WORD);
    assign is_wr_ph = (op_q == OP_WRITE_PAGE) ||
                      ((op_q == OP_CHIP_ERASE) && ph_q);
    assign is_ld_ph = (op_q == OP_LOAD_CMD) ||
                      (op_q == OP_LOAD_ADDR) ||
                      (op_q == OP_LOAD_DATA) ||
                      ((op_q == OP_CHIP_ERASE) && !ph_q);
    assign two_ph   = !ph_q && ((op_q == OP_LOAD_ADDR) ||
                                (op_q == OP_LOAD_DATA) ||
                                (op_q == OP_CHIP_ERASE));

    // Ready is held low until the first clock after reset release.
    assign bus.cmd_ready = (state_q == IDLE) && init_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = (state_q == RESP) && err_q;
    assign bus.rsp_data  = rsp_data_q;

    // Next-state: phase sequencing, counter reloads and data capture.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        opnd_d     = opnd_q;
        ph_d       = ph_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        err_d      = err_q;
        lo_d       = lo_q;
        rsp_data_d = rsp_data_q;
        init_d     = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    op_d   = bus.cmd_op;
                    opnd_d = bus.cmd_data;
                    ph_d   = 1'b0;
                    err_d  = 1'b0;
                    if (bus.cmd_op[2:1] == 2'b11) begin
                        state_d    = RESP;
                        err_d      = 1'b1;
                        rsp_data_d = '0;
                    end else begin
                        state_d = SETUP;
                        cnt_d   = SET_LD;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = PUL_LD;
                    state_d = is_rd ? SAMPLE : STROBE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (is_wr_ph) begin
                    state_d = WAIT_RDY;
                    wcnt_d  = '0;
                end else if (two_ph) begin
                    ph_d    = 1'b1;
                    state_d = SETUP;
                    cnt_d   = SET_LD;
                end else begin
                    state_d    = RESP;
                    rsp_data_d = '0;
                end
            end
            WAIT_RDY: begin
                // RDY is ignored on the first cycle so a slow busy flag
                // from the memory cannot be mistaken for completion.
                if (RDY && (wcnt_q != '0)) begin
                    state_d    = RESP;
                    rsp_data_d = '0;
                end else if (wcnt_q == W_LAST) begin
                    state_d    = RESP;
                    err_d      = 1'b1;
                    rsp_data_d = '0;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            SAMPLE: begin
                if (cnt_q == '0) begin
                    if (!ph_q) begin
                        lo_d    = data_in;
                        ph_d    = 1'b1;
                        state_d = SETUP;
                        cnt_d   = SET_LD;
                    end else begin
                        rsp_data_d = {data_in, lo_q};
                        state_d    = RESP;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin decode from registered state so reset idles the pins at once.
    always_comb begin
        XTAL1 = 1'b0;
        XA    = 2'b00;
        BS1   = 1'b0;
        WR    = 1'b1;
        OE    = 1'b1;
        DATA  = 8'h00;

        if (((state_q == SETUP) || (state_q == STROBE) ||
             (state_q == HOLD)) && is_ld_ph) begin
            XTAL1 = (state_q == STROBE);
            case (op_q)
                OP_LOAD_CMD: begin
                    XA   = 2'b10;
                    DATA = opnd_q[7:0];
                end
                OP_LOAD_ADDR: begin
                    BS1  = !ph_q;
                    DATA = ph_q ? opnd_q[7:0] : opnd_q[15:8];
                end
                OP_LOAD_DATA: begin
                    XA   = 2'b01;
                    BS1  = ph_q;
                    DATA = ph_q ? opnd_q[15:8] : opnd_q[7:0];
                end
                default: begin
                    XA   = 2'b10;
                    DATA = 8'h80;
                end
            endcase
        end

        if ((state_q == STROBE) && is_wr_ph) begin
            WR = 1'b0;
        end

        if (((state_q == SETUP) || (state_q == SAMPLE)) && is_rd) begin
            OE  = 1'b0;
            BS1 = ph_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            opnd_q     <= '0;
            ph_q       <= 1'b0;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            err_q      <= 1'b0;
            lo_q       <= '0;
            rsp_data_q <= '0;
            init_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            ph_q       <= ph_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            err_q      <= err_d;
            lo_q       <= lo_d;
            rsp_data_q <= rsp_data_d;
            init_q     <= init_d;
        end
    end

endmodule
